// File: rtl/complex_mult_pkg.sv
// Shared constants and the output-width rule for the complex multiplier.
// Output width is one bit wider than a single product so that the sum of two products always fits.
package complex_mult_pkg;

    localparam int DEF_DINA_WIDTH = 8;
    localparam int DEF_DINB_WIDTH = 8;

    function automatic int mult_width(input int a_width, input int b_width);
        return a_width + b_width + 1;
    endfunction

endpackage

// File: rtl/complex_mult_if.sv
// Sample-in / result-out bundle of the complex multiplier; valid-qualified, no ready.
// The master drives operands, the slave (the multiplier) drives results.
interface complex_mult_if
    import complex_mult_pkg::*;
#(
    parameter int DINA_WIDTH = DEF_DINA_WIDTH,
    parameter int DINB_WIDTH = DEF_DINB_WIDTH
);

    localparam int MULT_WIDTH = mult_width(DINA_WIDTH, DINB_WIDTH);

    logic                         din_valid;
    logic signed [DINA_WIDTH-1:0] dina_i;
    logic signed [DINA_WIDTH-1:0] dina_q;
    logic signed [DINB_WIDTH-1:0] dinb_i;
    logic signed [DINB_WIDTH-1:0] dinb_q;
    logic                         dout_valid;
    logic signed [MULT_WIDTH-1:0] mult_i;
    logic signed [MULT_WIDTH-1:0] mult_q;

    modport master (
        output din_valid, dina_i, dina_q, dinb_i, dinb_q,
        input  dout_valid, mult_i, mult_q
    );

    modport slave (
        input  din_valid, dina_i, dina_q, dinb_i, dinb_q,
        output dout_valid, mult_i, mult_q
    );

endinterface

// File: rtl/complex_mult_signed_mult.sv
// Registered signed multiplier; exact product sign-extended to P_WIDTH.
// Latency 1 cycle, updates every cycle, no backpressure.
module signed_mult #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [A_WIDTH-1:0] a,
    input  logic signed [B_WIDTH-1:0] b,
    output logic signed [P_WIDTH-1:0] p
);

    localparam int PROD_WIDTH = A_WIDTH + B_WIDTH;

    logic signed [PROD_WIDTH-1:0] prod;

    // Widen both operands first so the multiply is evaluated at full product width.
    assign prod = PROD_WIDTH'(a) * PROD_WIDTH'(b);

    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else begin
            p <= P_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/complex_mult.sv
// Pipelined full-precision signed complex multiplier: (a_i + j a_q) * (b_i + j b_q).
// Latency 2 cycles, one sample per cycle, no backpressure; data is don't-care when dout_valid is low.
module complex_mult
    import complex_mult_pkg::*;
#(
    parameter int DINA_WIDTH = DEF_DINA_WIDTH,
    parameter int DINB_WIDTH = DEF_DINB_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    complex_mult_if.slave  bus
);

    localparam int MULT_WIDTH = mult_width(DINA_WIDTH, DINB_WIDTH);

    logic signed [MULT_WIDTH-1:0] p_ii;
    logic signed [MULT_WIDTH-1:0] p_qq;
    logic signed [MULT_WIDTH-1:0] p_iq;
    logic signed [MULT_WIDTH-1:0] p_qi;
    logic                         s1_valid;

    signed_mult #(.A_WIDTH(DINA_WIDTH), .B_WIDTH(DINB_WIDTH), .P_WIDTH(MULT_WIDTH)) u_mult_ii (
        .clk (clk), .rst (rst), .a (bus.dina_i), .b (bus.dinb_i), .p (p_ii)
    );

    signed_mult #(.A_WIDTH(DINA_WIDTH), .B_WIDTH(DINB_WIDTH), .P_WIDTH(MULT_WIDTH)) u_mult_qq (
        .clk (clk), .rst (rst), .a (bus.dina_q), .b (bus.dinb_q), .p (p_qq)
    );

    signed_mult #(.A_WIDTH(DINA_WIDTH), .B_WIDTH(DINB_WIDTH), .P_WIDTH(MULT_WIDTH)) u_mult_iq (
        .clk (clk), .rst (rst), .a (bus.dina_i), .b (bus.dinb_q), .p (p_iq)
    );

    signed_mult #(.A_WIDTH(DINA_WIDTH), .B_WIDTH(DINB_WIDTH), .P_WIDTH(MULT_WIDTH)) u_mult_qi (
        .clk (clk), .rst (rst), .a (bus.dina_q), .b (bus.dinb_i), .p (p_qi)
    );

    // Valid travels alongside the products; reset flushes both stages so no stale valid survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            bus.dout_valid <= 1'b0;
            bus.mult_i     <= '0;
            bus.mult_q     <= '0;
        end else begin
            s1_valid       <= bus.din_valid;
            bus.dout_valid <= s1_valid;
            bus.mult_i     <= p_ii - p_qq;
            bus.mult_q     <= p_iq + p_qi;
        end
    end

endmodule

// File: tb/tb_complex_mult.sv
// Directed and random checks of complex_mult against a two-deep reference pipeline.
module tb_complex_mult;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    // Reference pipeline: stage 1 holds the expected result of the sample just captured.
    bit m1_v, mo_v;
    int m1_i, m1_q, mo_i, mo_q;

    complex_mult_if #(.DINA_WIDTH(8), .DINB_WIDTH(8)) bus ();

    complex_mult #(.DINA_WIDTH(8), .DINB_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input bit r, input int ai, input int aq, input int bi, input int bq);
        bus.din_valid = v;
        bus.dina_i    = 8'(ai);
        bus.dina_q    = 8'(aq);
        bus.dinb_i    = 8'(bi);
        bus.dinb_q    = 8'(bq);
        rst           = r;
        @(posedge clk);
        if (r) begin
            m1_v = 1'b0; m1_i = 0; m1_q = 0;
            mo_v = 1'b0; mo_i = 0; mo_q = 0;
        end else begin
            mo_v = m1_v; mo_i = m1_i; mo_q = m1_q;
            m1_v = v;
            m1_i = ai * bi - aq * bq;
            m1_q = ai * bq + aq * bi;
        end
        #1;
        check("dout_valid", 32'(bus.dout_valid), mo_v ? 1 : 0);
        if (mo_v) begin
            check("mult_i", 32'(bus.mult_i), mo_i);
            check("mult_q", 32'(bus.mult_q), mo_q);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m1_v = 1'b0; mo_v = 1'b0;
        m1_i = 0; m1_q = 0; mo_i = 0; mo_q = 0;
        rst           = 1'b1;
        bus.din_valid = 1'b0;
        bus.dina_i    = '0;
        bus.dina_q    = '0;
        bus.dinb_i    = '0;
        bus.dinb_q    = '0;

        // Reset with live-looking inputs: everything must read zero.
        step(1'b1, 1'b1, 5, 6, 7, 8);
        step(1'b1, 1'b1, 5, 6, 7, 8);
        check("reset_mult_i", 32'(bus.mult_i), 0);
        check("reset_mult_q", 32'(bus.mult_q), 0);

        // First sample after release appears two cycles later.
        step(1'b1, 1'b0, 4, 5, 5, 4);
        check("first_valid_early", 32'(bus.dout_valid), 0);
        step(1'b0, 1'b0, 0, 0, 0, 0);
        check("sweep_4_5_mult_i", 32'(bus.mult_i), 0);
        check("sweep_4_5_mult_q", 32'(bus.mult_q), 41);
        step(1'b0, 1'b0, 0, 0, 0, 0);

        // Sweep dina=(i,j), dinb=(j,i): real part cancels, imaginary is i^2+j^2.
        for (int i = 4; i <= 15; i++) begin
            for (int j = 4; j <= 15; j++) begin
                step(1'b1, 1'b0, i, j, j, i);
                if (mo_v) check("sweep_mult_i_zero", 32'(bus.mult_i), 0);
            end
        end
        step(1'b0, 1'b0, 0, 0, 0, 0);
        check("sweep_last_mult_q", 32'(bus.mult_q), 15 * 15 + 15 * 15);
        step(1'b0, 1'b0, 0, 0, 0, 0);

        // Most negative operands: imaginary result needs the extra top bit.
        step(1'b1, 1'b0, -128, -128, -128, -128);
        step(1'b0, 1'b0, 0, 0, 0, 0);
        check("extreme_mult_i", 32'(bus.mult_i), 0);
        check("extreme_mult_q", 32'(bus.mult_q), 32768);

        // Mixed signs: (-128 + j127) * (-128 - j128).
        step(1'b1, 1'b0, -128, 127, -128, -128);
        step(1'b0, 1'b0, 0, 0, 0, 0);
        check("mixed_mult_i", 32'(bus.mult_i), 32640);
        check("mixed_mult_q", 32'(bus.mult_q), 128);
        step(1'b0, 1'b0, 0, 0, 0, 0);

        // Single valid pulse: exactly one valid output, two cycles later.
        step(1'b1, 1'b0, 3, -2, 5, 7);
        check("pulse_valid_c1", 32'(bus.dout_valid), 0);
        step(1'b0, 1'b0, 9, 9, 9, 9);
        check("pulse_valid_c2", 32'(bus.dout_valid), 1);
        check("pulse_mult_i", 32'(bus.mult_i), 29);
        check("pulse_mult_q", 32'(bus.mult_q), 11);
        step(1'b0, 1'b0, 9, 9, 9, 9);
        check("pulse_valid_c3", 32'(bus.dout_valid), 0);

        // Reset mid-stream discards in-flight samples.
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, k + 1, -k, 2 * k, 3);
        step(1'b1, 1'b1, 11, 12, 13, 14);
        check("midrst_valid", 32'(bus.dout_valid), 0);
        check("midrst_mult_i", 32'(bus.mult_i), 0);
        check("midrst_mult_q", 32'(bus.mult_q), 0);
        step(1'b0, 1'b0, 1, 1, 1, 1);
        check("midrst_no_stale", 32'(bus.dout_valid), 0);
        step(1'b0, 1'b0, 1, 1, 1, 1);
        step(1'b1, 1'b0, 2, 3, 4, 5);
        check("resume_valid_c1", 32'(bus.dout_valid), 0);
        step(1'b1, 1'b0, 6, 7, 8, 9);
        check("resume_valid_c2", 32'(bus.dout_valid), 1);
        check("resume_mult_i", 32'(bus.mult_i), 2 * 4 - 3 * 5);
        check("resume_mult_q", 32'(bus.mult_q), 2 * 5 + 3 * 4);

        // Back-to-back random signed vectors.
        for (int n = 0; n < 1000; n++) begin
            step(($urandom_range(0, 7) != 0),
                 1'b0,
                 int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128);
        end
        step(1'b0, 1'b0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
